crack_job_dispatcher: RTL and testbench
=======================================

Name: crack_job_dispatcher

Overview:
Work dispatcher and initiator for the parallel brute-force cracker array. It accepts a target password and splits the first-character index space [0, CHARSET_SIZE-1] into CHUNK-wide ranges. Each range is handed to an idle worker over a valid/ready handshake. The block collects per-worker done/found reports and ends the job with a single found/done result, aborting all workers on the first hit.

Parameters:
NUM_WORKERS, 9, number of worker lanes
CHARSET_SIZE, 36, alphabet size; first-char indices 0..CHARSET_SIZE-1
CHUNK, 4, indices per assignment
IDX_W, 6, width of from/to index fields
PW_W, 32, target password width (4 chars x 8 bits)

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin job; sampled only in IDLE
target_pw  in  PW_W  password to crack; latched on accepted start
busy  out  1  high from accepted start until job_done
worker_pw  out  PW_W  latched target, broadcast to all workers
worker_from  out  IDX_W  range start of the current offer
worker_to  out  IDX_W  range end (inclusive) of the current offer
worker_valid  out  NUM_WORKERS  one-hot offer
worker_ready  in  NUM_WORKERS  worker can accept an assignment
worker_done  in  NUM_WORKERS  1-cycle pulse: assigned range finished
worker_found  in  NUM_WORKERS  1-cycle pulse: match found, valid with done
worker_abort  out  1  1-cycle broadcast stop
job_found  out  1  match found; held until next accepted start
found_worker  out  clog2(NUM_WORKERS)  index of reporting worker; held with job_found
job_done  out  1  1-cycle completion pulse
cycle_count  out  32  elapsed job cycles (see Optional Feature)

Behaviour:
- Reset rst is asynchronous and active-high; clock is clk. Reset sets all outputs to 0, outstanding bitmap to 0, next_from to 0, and the state to IDLE. Reset mid-job drops all offers and results with no abort pulse.
- States: IDLE, DISPATCH, DRAIN, FINISH.
- IDLE: start=1 latches target_pw into worker_pw, clears job_found, found_worker and outstanding, sets next_from=0 and busy=1, then enters DISPATCH. start is ignored in every other state.
- DISPATCH, no offer pending: choose the lowest-index worker with outstanding[i]=0. On the next cycle, register worker_valid=one-hot(i), worker_from=next_from, worker_to=min(next_from+CHUNK-1, CHARSET_SIZE-1).
- Handshake: an offer completes in the cycle worker_valid[i] & worker_ready[i]. On that edge: set outstanding[i], next_from += CHUNK, and drop worker_valid the following cycle. An offer is held stable until accepted.
- Offer rate: at most one offer at a time; the next offer may appear in the cycle after the handshake.
- DISPATCH to DRAIN: when next_from >= CHARSET_SIZE after a handshake. The comparison uses IDX_W+1 bits so there is no wrap.
- worker_done[i] with outstanding[i]=1 clears outstanding[i]. A done from a non-outstanding worker is ignored.
- DRAIN: when outstanding==0, go to FINISH with job_found=0.
- Any worker_found[i] & outstanding[i] in DISPATCH or DRAIN:
  - pulse worker_abort for 1 cycle, drop worker_valid, clear outstanding;
  - set job_found=1 and found_worker=i (lowest i if several are simultaneous);
  - go to FINISH. Found takes priority over done or handshake in the same cycle.
- FINISH: job_done=1 for exactly one cycle and busy=0, then return to IDLE.
- Latency: first offer appears 2 cycles after start is accepted. job_done appears 1 cycle after the last done, or 1 cycle after the found report.

Optional Feature:
CRACK_CYCLE_COUNT_EN
- Defined: a 32-bit counter clears on accepted start and increments every cycle while busy=1. It saturates at 0xFFFFFFFF. cycle_count holds its value after job_done until the next start.
- Undefined: cycle_count is tied to 0 and no counter logic is built.

Test Plan:
- Defaults, all workers always ready, each done 10 cycles after accept, no found -> 9 offers with ranges 0-3, 4-7, ..., 32-35 to workers 0..8 in order; job_done pulses once; job_found=0.
- Worker 4 pulses found+done on range 16-19 -> worker_abort 1 cycle; job_found=1; found_worker=4; job_done next cycle; no further offers.
- NUM_WORKERS=2, CHUNK=5 -> workers 0/1 reused across 8 offers; last range 35-35; job_done only after final done.
- Offer held with worker_ready=0 for 20 cycles -> worker_valid/from/to stable throughout; accept on ready rise.
- rst asserted mid-DISPATCH -> all outputs 0 immediately; start afterwards begins again at range 0-3.
- Found from worker 2 and done from worker 3 in the same cycle, plus start during busy -> found wins with found_worker=2; start ignored; with CRACK_CYCLE_COUNT_EN, cycle_count equals cycles from accept to job_done.

Source files
------------

// File: rtl/crack_job_dispatcher.sv
// crack_job_dispatcher
// Splits the first-character index space of the cracker into CHUNK-wide
// ranges, offers them one at a time to idle workers over valid/ready, and
// reduces the per-worker done/found reports into a single job result.
// The first found report aborts every worker and ends the job.
// Build option: define CRACK_CYCLE_COUNT_EN to build the job cycle counter;
// without it cycle_count is tied to zero.
//
// state    | meaning
// IDLE     | waiting for start; start latches the target password
// DISPATCH | offering ranges to idle workers and collecting reports
// DRAIN    | every range handed out; waiting for outstanding workers
// FINISH   | one-cycle job_done pulse, then back to IDLE
module crack_job_dispatcher #(
   parameter int NUM_WORKERS  = 9,
   parameter int CHARSET_SIZE = 36,
   parameter int CHUNK        = 4,
   parameter int IDX_W        = 6,
   parameter int PW_W         = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [PW_W-1:0]                target_pw,
   output logic                           busy,
   output logic [PW_W-1:0]                worker_pw,
   output logic [IDX_W-1:0]               worker_from,
   output logic [IDX_W-1:0]               worker_to,
   output logic [NUM_WORKERS-1:0]         worker_valid,
   input  logic [NUM_WORKERS-1:0]         worker_ready,
   input  logic [NUM_WORKERS-1:0]         worker_done,
   input  logic [NUM_WORKERS-1:0]         worker_found,
   output logic                           worker_abort,
   output logic                           job_found,
   output logic [$clog2(NUM_WORKERS)-1:0] found_worker,
   output logic                           job_done,
   output logic [31:0]                    cycle_count
);

   localparam int FW_W = $clog2(NUM_WORKERS);

   // One extra index bit so that stepping past the last range cannot wrap.
   localparam logic [IDX_W:0]       CHUNK_X = (IDX_W+1)'(CHUNK);
   localparam logic [IDX_W:0]       SIZE_X  = (IDX_W+1)'(CHARSET_SIZE);
   localparam logic [IDX_W:0]       ONE_X   = (IDX_W+1)'(1);
   localparam logic [IDX_W-1:0]     LAST_I  = IDX_W'(CHARSET_SIZE - 1);
   localparam logic [NUM_WORKERS-1:0] LANE0 = NUM_WORKERS'(1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPATCH = 2'd1,
      DRAIN    = 2'd2,
      FINISH   = 2'd3
   } state_t;

   state_t                 state;
   logic [NUM_WORKERS-1:0] outstanding;
   logic [IDX_W:0]         next_from;

   logic [NUM_WORKERS-1:0] hit;
   logic [NUM_WORKERS-1:0] accept;
   logic [NUM_WORKERS-1:0] still_out;
   logic [IDX_W:0]         from_adv;
   logic [IDX_W:0]         to_full;
   logic [IDX_W-1:0]       to_clip;
   logic                   have_idle;
   logic                   have_hit;
   logic [FW_W-1:0]        idle_idx;
   logic [FW_W-1:0]        hit_idx;

   // Only reports from workers that actually hold a range count.
   assign hit       = worker_found & outstanding;
   assign accept    = worker_valid & worker_ready;
   assign still_out = outstanding & ~worker_done;
   assign from_adv  = next_from + CHUNK_X;
   assign to_full   = from_adv - ONE_X;
   assign to_clip   = (to_full > {1'b0, LAST_I}) ? LAST_I : to_full[IDX_W-1:0];

   // Lowest-index idle worker and lowest-index finder.
   always_comb begin
      have_idle = 1'b0;
      idle_idx  = '0;
      have_hit  = 1'b0;
      hit_idx   = '0;
      for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
         if (!outstanding[i]) begin
            have_idle = 1'b1;
            idle_idx  = FW_W'(i);
         end
         if (hit[i]) begin
            have_hit = 1'b1;
            hit_idx  = FW_W'(i);
         end
      end
   end

   // Job sequencing, offer generation and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         outstanding  <= '0;
         next_from    <= '0;
         busy         <= 1'b0;
         worker_pw    <= '0;
         worker_from  <= '0;
         worker_to    <= '0;
         worker_valid <= '0;
         worker_abort <= 1'b0;
         job_found    <= 1'b0;
         found_worker <= '0;
         job_done     <= 1'b0;
      end else begin
         worker_abort <= 1'b0;
         job_done     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  worker_pw    <= target_pw;
                  job_found    <= 1'b0;
                  found_worker <= '0;
                  outstanding  <= '0;
                  next_from    <= '0;
                  busy         <= 1'b1;
                  state        <= DISPATCH;
               end
            end
            DISPATCH: begin
               if (have_hit) begin
                  // A hit outranks any done or handshake in the same cycle.
                  worker_abort <= 1'b1;
                  worker_valid <= '0;
                  outstanding  <= '0;
                  job_found    <= 1'b1;
                  found_worker <= hit_idx;
                  job_done     <= 1'b1;
                  busy         <= 1'b0;
                  state        <= FINISH;
               end else begin
                  outstanding <= still_out | accept;
                  if (|accept) begin
                     worker_valid <= '0;
                     next_from    <= from_adv;
                     if (from_adv >= SIZE_X) begin
                        state <= DRAIN;
                     end
                  end else if (!(|worker_valid) && have_idle) begin
                     worker_valid <= LANE0 << idle_idx;
                     worker_from  <= next_from[IDX_W-1:0];
                     worker_to    <= to_clip;
                  end
               end
            end
            DRAIN: begin
               if (have_hit) begin
                  worker_abort <= 1'b1;
                  worker_valid <= '0;
                  outstanding  <= '0;
                  job_found    <= 1'b1;
                  found_worker <= hit_idx;
                  job_done     <= 1'b1;
                  busy         <= 1'b0;
                  state        <= FINISH;
               end else begin
                  outstanding <= still_out;
                  // Finish on the same edge as the last done so job_done
                  // trails it by one cycle.
                  if (still_out == '0) begin
                     job_done <= 1'b1;
                     busy     <= 1'b0;
                     state    <= FINISH;
                  end
               end
            end
            FINISH: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef CRACK_CYCLE_COUNT_EN
   logic [31:0] cycle_q;

   // Job length counter: cleared on accepted start, saturating while busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_q <= '0;
      end else if (state == IDLE && start) begin
         cycle_q <= '0;
      end else if (busy && cycle_q != 32'hFFFF_FFFF) begin
         cycle_q <= cycle_q + 32'd1;
      end
   end

   assign cycle_count = cycle_q;
`else
   assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_crack_job_dispatcher.sv
// Randomised bench for crack_job_dispatcher. A worker-occupancy scoreboard
// predicts offer targets, range bounds, abort/done timing and the result.
module tb_crack_job_dispatcher;
   localparam int NW = 9;
   localparam int CS = 36;
   localparam int CH = 4;
   localparam int IW = 6;
   localparam int PW = 32;
   localparam int NR = (CS + CH - 1) / CH;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [PW-1:0] target_pw;
   logic          busy;
   logic [PW-1:0] worker_pw;
   logic [IW-1:0] worker_from;
   logic [IW-1:0] worker_to;
   logic [NW-1:0] worker_valid;
   logic [NW-1:0] worker_ready;
   logic [NW-1:0] worker_done;
   logic [NW-1:0] worker_found;
   logic          worker_abort;
   logic          job_found;
   logic [3:0]    found_worker;
   logic          job_done;
   logic [31:0]   cycle_count;

   logic          s_start;
   logic [PW-1:0] s_target_pw;
   logic          s_busy;
   logic [PW-1:0] s_worker_pw;
   logic [IW-1:0] s_worker_from;
   logic [IW-1:0] s_worker_to;
   logic [1:0]    s_worker_valid;
   logic [1:0]    s_worker_ready;
   logic [1:0]    s_worker_done;
   logic [1:0]    s_worker_found;
   logic          s_worker_abort;
   logic          s_job_found;
   logic [0:0]    s_found_worker;
   logic          s_job_done;
   logic [31:0]   s_cycle_count;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   crack_job_dispatcher u_dut (
      .clk(clk), .rst(rst), .start(start), .target_pw(target_pw), .busy(busy),
      .worker_pw(worker_pw), .worker_from(worker_from), .worker_to(worker_to),
      .worker_valid(worker_valid), .worker_ready(worker_ready),
      .worker_done(worker_done), .worker_found(worker_found),
      .worker_abort(worker_abort), .job_found(job_found),
      .found_worker(found_worker), .job_done(job_done), .cycle_count(cycle_count)
   );

   crack_job_dispatcher #(.NUM_WORKERS(2), .CHUNK(5)) u_small (
      .clk(clk), .rst(rst), .start(s_start), .target_pw(s_target_pw), .busy(s_busy),
      .worker_pw(s_worker_pw), .worker_from(s_worker_from), .worker_to(s_worker_to),
      .worker_valid(s_worker_valid), .worker_ready(s_worker_ready),
      .worker_done(s_worker_done), .worker_found(s_worker_found),
      .worker_abort(s_worker_abort), .job_found(s_job_found),
      .found_worker(s_found_worker), .job_done(s_job_done), .cycle_count(s_cycle_count)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   function automatic int lowest(input logic [NW-1:0] v);
      int r = -1;
      for (int i = NW - 1; i >= 0; i--) if (v[i]) r = i;
      return r;
   endfunction

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // dmode 0: fixed; 1: random; 2: offers 2/3 finish together; 3: offer 4 finishes early
   function automatic int delay_of(input int dmode, input int fix, input int k);
      case (dmode)
         0: return fix;
         1: return int'($urandom_range(1, 20));
         2: return (k == 2) ? 10 : (k == 3) ? 8 : 30;
         default: return (k == 4) ? 3 : 30;
      endcase
   endfunction

   function automatic logic [NW-1:0] ready_pat(input int rmode, input int hold, input int nh, input int c);
      if (hold > 0 && nh == 0 && c <= hold) return '0;
      if (rmode == 1) return NW'($urandom | $urandom);
      return '1;
   endfunction

   task automatic run_job(input int rmode, input int dmode, input int fix, input int found_off,
                          input int hold, input bit start_busy, input bit check_order);
      logic [NW-1:0] m_out, prev_v, hit, fin, hs, exp_v;
      logic [IW-1:0] pf, pt;
      logic [PW-1:0] pw;
      int done_at [NW];
      bit ff [NW];
      int n_hs, cyc, w, lf, exp_fw;
      bit ended, ab, dn, exp_found;
      pw = $urandom;
      @(negedge clk);
      start = 1'b1; target_pw = pw;
      worker_ready = '0; worker_done = '0; worker_found = '0;
      @(negedge clk);
      check("accept_busy", busy, 1);
      check("latched_pw", worker_pw, pw);
      check("found_cleared", job_found, 0);
      check("no_offer_yet", worker_valid, 0);
      start = start_busy; target_pw = ~pw;
      m_out = '0; prev_v = '0; pf = '0; pt = '0;
      n_hs = 0; cyc = 0; ended = 1'b0; exp_found = 1'b0; exp_fw = 0;
      for (int i = 0; i < NW; i++) begin done_at[i] = -1; ff[i] = 1'b0; end
      worker_ready = ready_pat(rmode, hold, 0, 0);
      while (!ended && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         hit = worker_found & m_out;
         fin = worker_done & m_out;
         ab  = (hit != '0);
         hs  = ab ? '0 : (prev_v & worker_ready);
         dn  = 1'b0;
         if (!ab && prev_v == '0 && worker_valid != '0) begin
            lf = lowest(~m_out);
            exp_v = (lf < 0) ? '0 : (NW'(1) << lf);
            check("offer_worker", worker_valid, exp_v);
            check("offer_from", worker_from, n_hs * CH);
            check("offer_to", worker_to, imin(n_hs * CH + CH - 1, CS - 1));
            if (n_hs == 0) check("first_offer_latency", cyc, 1);
            if (check_order) check("offer_order", worker_valid, NW'(1) << n_hs);
         end
         if (ab) begin
            exp_found = 1'b1; exp_fw = lowest(hit);
            m_out = '0; dn = 1'b1; ended = 1'b1;
            check("valid_dropped_on_found", worker_valid, 0);
         end else begin
            m_out = m_out & ~worker_done;
            if (hs != '0) begin
               w = lowest(hs);
               m_out[w] = 1'b1;
               done_at[w] = cyc + delay_of(dmode, fix, n_hs) - 1;
               ff[w] = (n_hs == found_off);
               n_hs++;
               check("valid_dropped_after_hs", worker_valid, 0);
            end else if (prev_v != '0) begin
               check("offer_valid_stable", worker_valid, prev_v);
               check("offer_from_stable", worker_from, pf);
               check("offer_to_stable", worker_to, pt);
            end
            dn = (fin != '0) && (m_out == '0) && (n_hs == NR);
            ended = dn;
         end
         check("worker_abort", worker_abort, ab);
         check("job_done", job_done, dn);
         check("busy", busy, !ended);
         if (!ended) begin
            worker_done = '0; worker_found = '0;
            for (int i = 0; i < NW; i++) begin
               if (m_out[i] && done_at[i] == cyc) begin
                  worker_done[i] = 1'b1; worker_found[i] = ff[i];
               end else if (!m_out[i] && rmode == 1 && $urandom_range(0, 15) == 0) begin
                  worker_done[i] = 1'b1; worker_found[i] = 1'($urandom_range(0, 1));
               end
            end
            worker_ready = ready_pat(rmode, hold, n_hs, cyc);
         end else begin
            worker_done = '0; worker_found = '0; worker_ready = '0; start = 1'b0;
         end
         prev_v = worker_valid; pf = worker_from; pt = worker_to;
      end
      check("job_finished_in_time", ended, 1);
      check("job_found", job_found, exp_found);
      check("found_worker", found_worker, exp_fw);
      if (!exp_found) check("ranges_dispatched", n_hs, NR);
`ifdef CRACK_CYCLE_COUNT_EN
      check("cycle_count", cycle_count, cyc);
`else
      check("cycle_count_tied", cycle_count, 0);
`endif
      @(negedge clk);
      check("done_single_pulse", job_done, 0);
      check("abort_single_pulse", worker_abort, 0);
      check("idle_not_busy", busy, 0);
      check("no_offer_after_job", worker_valid, 0);
      check("found_held", job_found, exp_found);
`ifdef CRACK_CYCLE_COUNT_EN
      check("cycle_count_held", cycle_count, cyc);
`endif
   endtask

   task automatic run_small();
      logic [1:0] mo, pv, fin, exp_v;
      int da [2];
      int nh, c, w;
      bit ended, dn;
      @(negedge clk);
      s_start = 1'b1; s_target_pw = $urandom;
      @(negedge clk);
      s_start = 1'b0; s_worker_ready = 2'b11;
      check("s_busy", s_busy, 1);
      mo = '0; pv = '0; nh = 0; c = 0; ended = 1'b0; da[0] = -1; da[1] = -1;
      while (!ended && c < 500) begin
         @(negedge clk);
         c++;
         if (pv == '0 && s_worker_valid != '0) begin
            exp_v = !mo[0] ? 2'b01 : !mo[1] ? 2'b10 : 2'b00;
            check("s_offer_worker", s_worker_valid, exp_v);
            check("s_offer_from", s_worker_from, nh * 5);
            check("s_offer_to", s_worker_to, imin(nh * 5 + 4, CS - 1));
         end
         fin = s_worker_done & mo;
         mo = mo & ~s_worker_done;
         if ((pv & s_worker_ready) != '0) begin
            w = pv[0] ? 0 : 1;
            mo[w] = 1'b1; da[w] = c + 2; nh++;
         end
         dn = (fin != '0) && (mo == '0) && (nh == 8);
         ended = dn;
         check("s_job_done", s_job_done, dn);
         s_worker_done = '0;
         for (int i = 0; i < 2; i++) if (mo[i] && da[i] == c) s_worker_done[i] = 1'b1;
         pv = s_worker_valid;
      end
      check("s_finished_in_time", ended, 1);
      check("s_offers", nh, 8);
      check("s_job_found", s_job_found, 0);
      s_worker_ready = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int fo;
      rst = 1'b1; start = 1'b0; target_pw = '0;
      worker_ready = '0; worker_done = '0; worker_found = '0;
      s_start = 1'b0; s_target_pw = '0; s_worker_ready = '0; s_worker_done = '0; s_worker_found = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_valid", worker_valid, 0);
      check("rst_pw", worker_pw, 0);
      check("rst_done", job_done, 0);
      check("rst_found", job_found, 0);
      check("rst_count", cycle_count, 0);
      rst = 1'b0;

      run_job(0, 0, 20, -1, 0, 1'b0, 1'b1);   // all ready, in-order ranges
      run_job(0, 3, 0, 4, 0, 1'b0, 1'b1);     // worker 4 finds on 16-19
      run_job(0, 0, 20, -1, 20, 1'b0, 1'b1);  // first offer held 20 cycles
      run_job(0, 2, 0, 2, 0, 1'b1, 1'b1);     // found w2 with done w3, start held

      // Asynchronous reset in the middle of DISPATCH.
      @(negedge clk);
      start = 1'b1; target_pw = $urandom | 32'h1; worker_ready = '0;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_rst_offer", worker_valid, 9'b1);
      check("pre_rst_to", worker_to, 3);
      #2 rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_valid", worker_valid, 0);
      check("midrst_to", worker_to, 0);
      check("midrst_pw", worker_pw, 0);
      check("midrst_abort", worker_abort, 0);
      check("midrst_count", cycle_count, 0);
      @(negedge clk);
      rst = 1'b0;
      run_job(0, 0, 20, -1, 0, 1'b0, 1'b1);

      for (int j = 0; j < 8; j++) begin
         fo = int'($urandom_range(0, 12));
         if (fo > 8) fo = -1;
         run_job(1, 1, 0, fo, 0, 1'($urandom_range(0, 1)), 1'b0);
      end

      run_small();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
